// File: rtl/cpu_reg_pkg.sv
// Shared register-addressing types for the write-back path and the register-file controller.
// A register's flat index is {gfflag, num}: general registers 0..15, float registers 16..31.
package cpu_reg_pkg;

    typedef struct packed {
        logic       gfflag;
        logic [3:0] num;
    } regaddr_t;

    localparam int NREGS = 32;

    typedef logic [31:0] word_t;

    function automatic logic [4:0] regIndex(input regaddr_t a);
        return {a.gfflag, a.num};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after the pointer, wrapping at NREQ.
// The caller owns the pointer register.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] gntIdx_o,
    output logic             gntValid_o
);

    int cand;

    always_comb begin
        gnt_o      = '0;
        gntIdx_o   = '0;
        gntValid_o = 1'b0;
        cand       = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr_i) + off) % NREQ;
            if (!gntValid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gntIdx_o    = IDX_W'(cand);
                gntValid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port among NREQ write-back sources (one write per cycle,
// round-robin) and keeps the pending-write scoreboard the issue stage uses for RAW stalls.
module reg_wb_arbiter
    import cpu_reg_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_gfflag,
    input  logic [NREQ*NUM_W-1:0]    req_num,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     wb_enable,
    output logic                     wb_gfflag,
    output logic [NUM_W-1:0]         wb_num,
    output logic [DATA_W-1:0]        wb_data,
    input  logic                     claim_valid,
    input  logic                     claim_gfflag,
    input  logic [NUM_W-1:0]         claim_num,
    input  logic                     rs_gfflag,
    input  logic [NUM_W-1:0]         rs_num,
    input  logic                     rt_gfflag,
    input  logic [NUM_W-1:0]         rt_num,
    output logic                     rs_busy,
    output logic                     rt_busy,
    output logic [2**(NUM_W+1)-1:0]  busy_mask
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BUSY_W = 2 ** (NUM_W + 1);

    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gntIdx;
    logic              gntValid;
    logic              xfer;

    logic              selGf;
    logic [NUM_W-1:0]  selNum;
    logic [DATA_W-1:0] selData;

    logic [IDX_W-1:0]  ptr_q,    ptr_d;
    logic              wbEn_q,   wbEn_d;
    logic              wbGf_q,   wbGf_d;
    logic [NUM_W-1:0]  wbNum_q,  wbNum_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic [BUSY_W-1:0] busy_q,   busy_d;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .gntIdx_o   (gntIdx),
        .gntValid_o (gntValid)
    );

    // Nothing is accepted while reset is asserted, even if a source misbehaves.
    assign req_ready = rstn ? gnt : '0;
    assign xfer      = rstn & gntValid;

    always_comb begin
        selGf   = 1'b0;
        selNum  = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                selGf   = req_gfflag[i];
                selNum  = req_num[i*NUM_W +: NUM_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        wbEn_d   = xfer;
        wbGf_d   = wbGf_q;
        wbNum_d  = wbNum_q;
        wbData_d = wbData_q;
        if (xfer) begin
            ptr_d    = (gntIdx == IDX_W'(NREQ - 1)) ? '0 : gntIdx + 1'b1;
            wbGf_d   = selGf;
            wbNum_d  = selNum;
            wbData_d = selData;
        end
    end

    // Clear first so a same-edge claim of the register being written leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[{selGf, selNum}] = 1'b0;
        end
        if (claim_valid) begin
            busy_d[{claim_gfflag, claim_num}] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q    <= '0;
            wbEn_q   <= 1'b0;
            wbGf_q   <= 1'b0;
            wbNum_q  <= '0;
            wbData_q <= '0;
            busy_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wbEn_q   <= wbEn_d;
            wbGf_q   <= wbGf_d;
            wbNum_q  <= wbNum_d;
            wbData_q <= wbData_d;
            busy_q   <= busy_d;
        end
    end

    assign wb_enable = wbEn_q;
    assign wb_gfflag = wbGf_q;
    assign wb_num    = wbNum_q;
    assign wb_data   = wbData_q;
    assign busy_mask = busy_q;
    assign rs_busy   = busy_q[{rs_gfflag, rs_num}];
    assign rt_busy   = busy_q[{rt_gfflag, rt_num}];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: expected writes are queued when a handshake is seen
// and compared against wb_* one cycle later; the scoreboard and pointer are modelled in the bench.
module tb_reg_wb_arbiter;
    import cpu_reg_pkg::*;

    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int NUM_W  = 4;

    typedef struct {
        logic        gf;
        logic [3:0]  num;
        logic [31:0] data;
    } wbExp_t;

    logic                    clk;
    logic                    rstn;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         req_gfflag;
    logic [NREQ*NUM_W-1:0]   req_num;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic                    wb_enable;
    logic                    wb_gfflag;
    logic [NUM_W-1:0]        wb_num;
    logic [DATA_W-1:0]       wb_data;
    logic                    claim_valid;
    logic                    claim_gfflag;
    logic [NUM_W-1:0]        claim_num;
    logic                    rs_gfflag;
    logic [NUM_W-1:0]        rs_num;
    logic                    rt_gfflag;
    logic [NUM_W-1:0]        rt_num;
    logic                    rs_busy;
    logic                    rt_busy;
    logic [31:0]             busy_mask;

    int          vecCount  = 0;
    int          missCount = 0;
    wbExp_t      expQ[$];
    wbExp_t      mLast;
    logic [31:0] mBusy;
    int          mPtr;
    bit          mValid = 0;
    int          lastGrant;
    logic [2:0]  obsReady;
    int          wbHigh;
    regaddr_t    ra;

    reg_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .NUM_W(NUM_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_gfflag   (req_gfflag),
        .req_num      (req_num),
        .req_data     (req_data),
        .wb_enable    (wb_enable),
        .wb_gfflag    (wb_gfflag),
        .wb_num       (wb_num),
        .wb_data      (wb_data),
        .claim_valid  (claim_valid),
        .claim_gfflag (claim_gfflag),
        .claim_num    (claim_num),
        .rs_gfflag    (rs_gfflag),
        .rs_num       (rs_num),
        .rt_gfflag    (rt_gfflag),
        .rt_num       (rt_num),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .busy_mask    (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int i, input logic gf, input logic [3:0] num, input logic [31:0] data);
        req_gfflag[i]          = gf;
        req_num[i*NUM_W +: 4]  = num;
        req_data[i*DATA_W +: 32] = data;
    endtask

    task automatic resetModel();
        mBusy = '0;
        mPtr  = 0;
        expQ.delete();
        mLast.gf   = 1'b0;
        mLast.num  = '0;
        mLast.data = '0;
    endtask

    // Called just after a negedge with inputs driven; returns at the following negedge.
    task automatic applyStimulus();
        int          g;
        int          c;
        logic [2:0]  expReady;
        wbExp_t      e;
        #1;
        g = -1;
        if (rstn) begin
            for (int off = 0; off < NREQ; off++) begin
                c = (mPtr + off) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        obsReady = req_ready;
        checkOutput("ready", req_ready, expReady);
        if (mValid) begin
            checkOutput("rs_busy", rs_busy, mBusy[{rs_gfflag, rs_num}]);
            checkOutput("rt_busy", rt_busy, mBusy[{rt_gfflag, rt_num}]);
        end
        lastGrant = g;
        if (!rstn) begin
            resetModel();
            mValid = 1;
        end else begin
            if (g >= 0) begin
                e.gf   = req_gfflag[g];
                e.num  = req_num[g*NUM_W +: 4];
                e.data = req_data[g*DATA_W +: 32];
                expQ.push_back(e);
                mPtr = (g + 1) % NREQ;
                mBusy[{e.gf, e.num}] = 1'b0;
            end
            if (claim_valid) mBusy[{claim_gfflag, claim_num}] = 1'b1;
        end
        @(negedge clk);
        if (mValid) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("wb_enable", wb_enable, 1);
                checkOutput("wb_gfflag", wb_gfflag, e.gf);
                checkOutput("wb_num", wb_num, e.num);
                checkOutput("wb_data", wb_data, e.data);
                mLast = e;
            end else begin
                checkOutput("wb_idle", wb_enable, 0);
                checkOutput("wb_hold_gf", wb_gfflag, mLast.gf);
                checkOutput("wb_hold_num", wb_num, mLast.num);
                checkOutput("wb_hold_data", wb_data, mLast.data);
            end
            checkOutput("busy_mask", busy_mask, mBusy);
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = '0; req_gfflag = '0; req_num = '0; req_data = '0;
        claim_valid = 1'b0; claim_gfflag = 1'b0; claim_num = '0;
        rs_gfflag = 1'b0; rs_num = '0; rt_gfflag = 1'b0; rt_num = '0;
        resetModel();

        // Reset with random inputs.
        for (int k = 0; k < 3; k++) begin
            req_valid = 3'($urandom); req_gfflag = 3'($urandom);
            req_num = 12'($urandom); req_data = {$urandom, $urandom, $urandom};
            claim_valid = 1'b1; claim_gfflag = 1'($urandom); claim_num = 4'($urandom);
            rs_gfflag = 1'($urandom); rs_num = 4'($urandom);
            applyStimulus();
            checkOutput("rst_ready", obsReady, 0);
            checkOutput("rst_wb_en", wb_enable, 0);
            checkOutput("rst_busy", busy_mask, 0);
        end
        rstn = 1'b1; req_valid = '0; claim_valid = 1'b0;

        // Round-robin: all three valid for six cycles.
        wbHigh = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = 1'b1;
            setReq(i, 1'b0, 4'(i + 1), 32'hA000_0000 + i);
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            checkOutput("rr_order", obsReady, 3'b001 << (k % 3));
            wbHigh += int'(wb_enable);
            if (lastGrant >= 0) setReq(lastGrant, 1'b0, 4'(lastGrant + 1), 32'hB000_0000 + k);
        end
        checkOutput("rr_wb_count", wbHigh, 6);
        req_valid = '0;
        applyStimulus();

        // Single write from requester 0.
        req_valid[0] = 1'b1;
        setReq(0, 1'b1, 4'd5, 32'hDEADBEEF);
        applyStimulus();
        checkOutput("single_ready", obsReady, 3'b001);
        checkOutput("single_en", wb_enable, 1);
        checkOutput("single_addr", {wb_gfflag, wb_num}, 5'h15);
        checkOutput("single_data", wb_data, 32'hDEADBEEF);
        req_valid = '0;
        applyStimulus();
        checkOutput("single_en_off", wb_enable, 0);

        // Scoreboard set by claim, cleared by requester 1 writing the same register.
        claim_valid = 1'b1; claim_gfflag = 1'b0; claim_num = 4'd7;
        rs_gfflag = 1'b0; rs_num = 4'd7;
        applyStimulus();
        claim_valid = 1'b0;
        checkOutput("claim_rs_busy", rs_busy, 1);
        req_valid[1] = 1'b1;
        setReq(1, 1'b0, 4'd7, 32'h0000_0777);
        applyStimulus();
        req_valid = '0;
        checkOutput("clear_rs_busy", rs_busy, 0);

        // Same-edge claim and clear of {1,3}: set wins.
        claim_valid = 1'b1; claim_gfflag = 1'b1; claim_num = 4'd3;
        applyStimulus();
        req_valid[2] = 1'b1;
        setReq(2, 1'b1, 4'd3, 32'h3333_0003);
        applyStimulus();
        req_valid = '0; claim_valid = 1'b0;
        ra.gfflag = 1'b1; ra.num = 4'd3;
        checkOutput("conflict_busy19", busy_mask[regIndex(ra)], 1);

        // Random traffic; a requester holds its fields until granted.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (lastGrant == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    setReq(i, 1'($urandom), 4'($urandom), $urandom);
                end
            end
            claim_valid = 1'($urandom); claim_gfflag = 1'($urandom); claim_num = 4'($urandom);
            rs_gfflag = 1'($urandom); rs_num = 4'($urandom);
            rt_gfflag = 1'($urandom); rt_num = 4'($urandom);
            applyStimulus();
        end
        req_valid = '0;

        // Reset landing on the edge that ends a transfer cycle.
        claim_valid = 1'b1; claim_gfflag = 1'b0; claim_num = 4'd2;
        applyStimulus();
        claim_valid = 1'b0;
        req_valid[0] = 1'b1;
        setReq(0, 1'b0, 4'd9, 32'h1234_5678);
        #1;
        checkOutput("mid_ready", req_ready, 3'b001);
        #2;
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("mid_wb_en", wb_enable, 0);
        checkOutput("mid_busy", busy_mask, 0);
        checkOutput("mid_wb_data", wb_data, 0);
        resetModel();
        req_valid = '0;
        applyStimulus();
        rstn = 1'b1;
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
